// File: rtl/axil_slv_pkg.sv
// Shared types and constants for the AXI4-Lite register bank.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package axil_slv_pkg;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] AXIL_SLV_ID = 32'hA11C_0001;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_RESP} rd_state_t;

  // Replace only the byte lanes whose strobe bit is set
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_val[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axil_slv_regfile.sv
// Register array with byte-strobed write port, combinational read port and range flags.
// Latency: write lands on the clock edge where wr_en is high; read data is combinational.
// Backpressure: none; AXI handshaking lives in the parent. Optional macro AXIL_SLV_ID_REG_EN.
module axil_slv_regfile
  import axil_slv_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int NUM_REGS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-3:0]        wr_idx,
  input  logic [31:0]              wr_data,
  input  logic [3:0]               wr_strb,
  output logic                     wr_ok,
  input  logic [ADDR_W-3:0]        rd_idx,
  output logic [31:0]              rd_data,
  output logic                     rd_ok,
  output logic [NUM_REGS*32-1:0]   reg_out
);

  localparam int IDX_W = ADDR_W - 2;
`ifdef AXIL_SLV_ID_REG_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif
  // With the ID register present the top slot is read-only
  localparam int NUM_RW = ID_EN ? NUM_REGS - 1 : NUM_REGS;

  logic [NUM_REGS-1:0][31:0] regs;

  assign rd_ok   = (rd_idx < IDX_W'(NUM_REGS));
  assign wr_ok   = (wr_idx < IDX_W'(NUM_RW));
  assign reg_out = regs;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    if (ID_EN && (k == NUM_REGS - 1)) begin : g_id
      assign regs[k] = AXIL_SLV_ID;
    end else begin : g_rw
      logic [31:0] q;
      // Byte-strobed update when this slot is the accepted write target
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          q <= '0;
        end else if (wr_en && wr_ok && (wr_idx == IDX_W'(k))) begin
          q <= merge_bytes(q, wr_data, wr_strb);
        end
      end
      assign regs[k] = q;
    end
  end

  // Read mux; an index that matches no slot yields zero
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_idx == IDX_W'(k)) rd_data = regs[k];
    end
  end

endmodule

// File: rtl/axil_slv_regs.sv
// AXI4-Lite responder exposing NUM_REGS 32-bit registers, contents also exported flat.
// Latency: bvalid/rvalid one cycle after the completing handshake; reads at most every 2 cycles.
// Backpressure: one outstanding op per direction; readies drop until the response is taken. Optional macro AXIL_SLV_ID_REG_EN.
module axil_slv_regs
  import axil_slv_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int NUM_REGS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      s_axi_awaddr,
  input  logic [2:0]             s_axi_awprot,
  input  logic                   s_axi_awvalid,
  output logic                   s_axi_awready,
  input  logic [31:0]            s_axi_wdata,
  input  logic [3:0]             s_axi_wstrb,
  input  logic                   s_axi_wvalid,
  output logic                   s_axi_wready,
  output logic [1:0]             s_axi_bresp,
  output logic                   s_axi_bvalid,
  input  logic                   s_axi_bready,
  input  logic [ADDR_W-1:0]      s_axi_araddr,
  input  logic [2:0]             s_axi_arprot,
  input  logic                   s_axi_arvalid,
  output logic                   s_axi_arready,
  output logic [31:0]            s_axi_rdata,
  output logic [1:0]             s_axi_rresp,
  output logic                   s_axi_rvalid,
  input  logic                   s_axi_rready,
  output logic [NUM_REGS*32-1:0] reg_out
);

  localparam int IDX_W = ADDR_W - 2;

  wr_state_t         wr_state;
  rd_state_t         rd_state;
  logic              rdy_en;
  logic [IDX_W-1:0]  aw_idx_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              aw_hs, w_hs, ar_hs, wr_go;
  logic [IDX_W-1:0]  wr_idx;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic              wr_ok, rd_ok;
  logic [31:0]       rd_data;

  // Protection bits and byte offset within a word carry no meaning here
  logic unused_ok;
  assign unused_ok = &{1'b0, s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // Hold all readies low until the first edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdy_en <= 1'b0;
    else      rdy_en <= 1'b1;
  end

  assign s_axi_awready = rdy_en && ((wr_state == W_IDLE) || (wr_state == W_HAVE_D));
  assign s_axi_wready  = rdy_en && ((wr_state == W_IDLE) || (wr_state == W_HAVE_A));
  assign s_axi_arready = rdy_en && (rd_state == R_IDLE);
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid  && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  // Pick address/data from the live channel or the latched half, and flag completion
  always_comb begin
    wr_go   = 1'b0;
    wr_idx  = s_axi_awaddr[ADDR_W-1:2];
    wr_data = s_axi_wdata;
    wr_strb = s_axi_wstrb;
    case (wr_state)
      W_IDLE:   wr_go = aw_hs && w_hs;
      W_HAVE_A: begin
        wr_go  = w_hs;
        wr_idx = aw_idx_q;
      end
      W_HAVE_D: begin
        wr_go   = aw_hs;
        wr_data = wdata_q;
        wr_strb = wstrb_q;
      end
      default:  wr_go = 1'b0;
    endcase
  end

  axil_slv_regfile #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_go),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .wr_ok   (wr_ok),
    .rd_idx  (s_axi_araddr[ADDR_W-1:2]),
    .rd_data (rd_data),
    .rd_ok   (rd_ok),
    .reg_out (reg_out)
  );

  // Write FSM: gather AW and W in either order, then hold the response until taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state     <= W_IDLE;
      aw_idx_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
    end else if (wr_go) begin
      wr_state     <= W_RESP;
      s_axi_bvalid <= 1'b1;
      s_axi_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_idx_q <= s_axi_awaddr[ADDR_W-1:2];
            wr_state <= W_HAVE_A;
          end else if (w_hs) begin
            wdata_q  <= s_axi_wdata;
            wstrb_q  <= s_axi_wstrb;
            wr_state <= W_HAVE_D;
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            wr_state     <= W_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // Read FSM: capture data on the AR handshake (pre-write value on a same-edge write)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state     <= R_IDLE;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (ar_hs) begin
            s_axi_rdata  <= rd_data;
            s_axi_rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            s_axi_rvalid <= 1'b1;
            rd_state     <= R_RESP;
          end
        end
        R_RESP: begin
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            rd_state     <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_slv_regs.sv
// Directed bench for axil_slv_regs with a word-level register model and per-cycle compare.
module tb_axil_slv_regs;
  import axil_slv_pkg::*;

  localparam int ADDR_W   = 16;
  localparam int NUM_REGS = 8;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [ADDR_W-1:0]      s_axi_awaddr;
  logic [2:0]             s_axi_awprot;
  logic                   s_axi_awvalid;
  logic                   s_axi_awready;
  logic [31:0]            s_axi_wdata;
  logic [3:0]             s_axi_wstrb;
  logic                   s_axi_wvalid;
  logic                   s_axi_wready;
  logic [1:0]             s_axi_bresp;
  logic                   s_axi_bvalid;
  logic                   s_axi_bready;
  logic [ADDR_W-1:0]      s_axi_araddr;
  logic [2:0]             s_axi_arprot;
  logic                   s_axi_arvalid;
  logic                   s_axi_arready;
  logic [31:0]            s_axi_rdata;
  logic [1:0]             s_axi_rresp;
  logic                   s_axi_rvalid;
  logic                   s_axi_rready;
  logic [NUM_REGS*32-1:0] reg_out;

  always #5 clk = ~clk;

  axil_slv_regs #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .reg_out(reg_out)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: register words plus the protocol phase as the bench drives it
  logic [31:0] model [NUM_REGS];
  bit          en, aw_got, w_got, wr_pend, rd_pend;
  logic [1:0]  exp_bresp, exp_rresp;
  logic [31:0] exp_rdata;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit idx_rd_ok(input int idx);
    return idx < NUM_REGS;
  endfunction

  function automatic bit idx_wr_ok(input int idx);
`ifdef AXIL_SLV_ID_REG_EN
    return idx < NUM_REGS - 1;
`else
    return idx < NUM_REGS;
`endif
  endfunction

  function automatic logic [255:0] model_flat();
    logic [255:0] f;
    f = '0;
    for (int k = 0; k < NUM_REGS; k++) f[32*k +: 32] = model[k];
    return f;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_REGS; k++) model[k] = 32'h0;
`ifdef AXIL_SLV_ID_REG_EN
    model[NUM_REGS-1] = AXIL_SLV_ID;
`endif
  endtask

  // Per-cycle comparison of every observable output against the model
  always @(negedge clk) begin
    check("awready", 256'(s_axi_awready), 256'(en && !aw_got && !wr_pend));
    check("wready",  256'(s_axi_wready),  256'(en && !w_got && !wr_pend));
    check("arready", 256'(s_axi_arready), 256'(en && !rd_pend));
    check("bvalid",  256'(s_axi_bvalid),  256'(wr_pend));
    check("rvalid",  256'(s_axi_rvalid),  256'(rd_pend));
    if (wr_pend) check("bresp", 256'(s_axi_bresp), 256'(exp_bresp));
    if (rd_pend) begin
      check("rdata", 256'(s_axi_rdata), 256'(exp_rdata));
      check("rresp", 256'(s_axi_rresp), 256'(exp_rresp));
    end
    check("reg_out", 256'(reg_out), model_flat());
  end

  // Drive one write; aw_dly/w_dly delay each channel's valid, b_dly stalls bready
  task automatic axi_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
    int cyc = 0;
    int idx = int'(addr[15:2]);
    bit ahs, whs, bhs;
    resp = 2'bxx;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    while (!(aw_got && w_got) && cyc < 50) begin
      s_axi_awvalid = !aw_got && (cyc >= aw_dly);
      s_axi_wvalid  = !w_got && (cyc >= w_dly);
      @(negedge clk);
      ahs = s_axi_awvalid && s_axi_awready;
      whs = s_axi_wvalid && s_axi_wready;
      @(posedge clk); #1;
      if (ahs) aw_got = 1;
      if (whs) w_got = 1;
      cyc++;
    end
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    if (!(aw_got && w_got)) begin
      check("wr_timeout", 256'(0), 256'(1));
      aw_got = 0; w_got = 0;
      return;
    end
    exp_bresp = idx_wr_ok(idx) ? RESP_OKAY : RESP_SLVERR;
    if (idx_wr_ok(idx)) begin
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
    end
    aw_got = 0; w_got = 0; wr_pend = 1;
    check("b_latency", 256'(s_axi_bvalid), 256'(1));
    resp = s_axi_bresp;
    repeat (b_dly) begin @(posedge clk); #1; end
    s_axi_bready = 1;
    bhs = 0; cyc = 0;
    while (!bhs && cyc < 50) begin
      @(negedge clk); bhs = s_axi_bvalid && s_axi_bready;
      @(posedge clk); #1; cyc++;
    end
    if (!bhs) check("b_timeout", 256'(0), 256'(1));
    wr_pend = 0; s_axi_bready = 0;
  endtask

  // Drive one read; r_dly stalls rready; expectation taken from the model before the edge
  task automatic axi_read(input logic [15:0] addr, input int r_dly,
                          output logic [31:0] got, output logic [1:0] resp);
    int cyc = 0;
    int idx = int'(addr[15:2]);
    bit hs = 0, rhs = 0;
    got = 'x; resp = 'x;
    s_axi_araddr = addr; s_axi_arvalid = 1;
    while (!hs && cyc < 50) begin
      @(negedge clk);
      hs = s_axi_arvalid && s_axi_arready;
      if (hs) begin
        if (idx_rd_ok(idx)) begin exp_rdata = model[idx]; exp_rresp = RESP_OKAY; end
        else begin exp_rdata = 32'h0; exp_rresp = RESP_SLVERR; end
      end
      @(posedge clk); #1; cyc++;
    end
    s_axi_arvalid = 0;
    if (!hs) begin check("ar_timeout", 256'(0), 256'(1)); return; end
    rd_pend = 1;
    check("r_latency", 256'(s_axi_rvalid), 256'(1));
    got = s_axi_rdata; resp = s_axi_rresp;
    repeat (r_dly) begin @(posedge clk); #1; end
    s_axi_rready = 1; cyc = 0;
    while (!rhs && cyc < 50) begin
      @(negedge clk); rhs = s_axi_rvalid && s_axi_rready;
      @(posedge clk); #1; cyc++;
    end
    if (!rhs) check("r_timeout", 256'(0), 256'(1));
    rd_pend = 0; s_axi_rready = 0;
  endtask

  logic [31:0] got, got2;
  logic [1:0]  br, rr, br2, rr2;
  bit          ahs0;

  initial begin
    s_axi_awaddr = '0; s_axi_awprot = 3'b0; s_axi_awvalid = 0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 0; s_axi_bready = 0;
    s_axi_araddr = '0; s_axi_arprot = 3'b0; s_axi_arvalid = 0; s_axi_rready = 0;
    en = 0; aw_got = 0; w_got = 0; wr_pend = 0; rd_pend = 0;
    model_reset();
    repeat (3) @(posedge clk); #1;

    // Reset state, literal
    check("rst_awready", 256'(s_axi_awready), 256'(0));
    check("rst_bvalid",  256'(s_axi_bvalid),  256'(0));
    check("rst_rdata",   256'(s_axi_rdata),   256'(0));
    check("rst_reg_out", 256'(reg_out[223:0]), 256'(0));
    rst = 1;
    @(posedge clk); #1; en = 1;

    // Full-word write then read back
    axi_write(16'h0010, 32'hDEADBEEF, 4'hF, 0, 0, 0, br);
    check("t1_bresp", 256'(br), 256'(2'b00));
    check("t1_reg_out", 256'(reg_out[159:128]), 256'(32'hDEADBEEF));
    axi_read(16'h0010, 0, got, rr);
    check("t1_rdata", 256'(got), 256'(32'hDEADBEEF));
    check("t1_rresp", 256'(rr), 256'(2'b00));

    // Partial strobe merge
    axi_write(16'h0004, 32'h11223344, 4'hF, 0, 0, 0, br);
    axi_write(16'h0004, 32'hAABBCCDD, 4'b0011, 0, 0, 0, br);
    axi_read(16'h0004, 0, got, rr);
    check("t2_rdata", 256'(got), 256'(32'h1122CCDD));

    // AW ahead of W, then W ahead of AW (address low bits ignored)
    axi_write(16'h0008, 32'h01020304, 4'hF, 0, 3, 0, br);
    check("t3a_reg", 256'(reg_out[95:64]), 256'(32'h01020304));
    axi_write(16'h000B, 32'h0A0B0C0D, 4'hF, 3, 0, 0, br);
    check("t3b_reg", 256'(reg_out[95:64]), 256'(32'h0A0B0C0D));

    // Out of range window
    axi_write(16'h0020, 32'hFFFFFFFF, 4'hF, 0, 0, 0, br);
    check("t4_bresp", 256'(br), 256'(2'b10));
    check("t4_reg_out", 256'(reg_out), 256'({32'h0, 32'h0, 32'h0, 32'hDEADBEEF,
                                               32'h0, 32'h0A0B0C0D, 32'h1122CCDD, 32'h0}));
    axi_read(16'h0020, 0, got, rr);
    check("t4_rdata", 256'(got), 256'(0));
    check("t4_rresp", 256'(rr), 256'(2'b10));

    // Response stalls: stable valids and blocked readies for 5 cycles
    axi_write(16'h0000, 32'hCAFEF00D, 4'hF, 0, 0, 5, br);
    axi_read(16'h0000, 5, got, rr);
    check("t5_rdata", 256'(got), 256'(32'hCAFEF00D));

    // Same-edge read and write of one register: read sees the old value
    fork
      axi_write(16'h000C, 32'h55AA55AA, 4'hF, 0, 0, 0, br2);
      axi_read(16'h000C, 0, got2, rr2);
    join
    check("t6_old_val", 256'(got2), 256'(0));
    check("t6_new_reg", 256'(reg_out[127:96]), 256'(32'h55AA55AA));

    // Reset while holding an address with no data yet
    s_axi_awaddr = 16'h0008; s_axi_awvalid = 1;
    @(negedge clk); ahs0 = s_axi_awvalid && s_axi_awready;
    @(posedge clk); #1;
    aw_got = ahs0; s_axi_awvalid = 0;
    check("t7_have_a", 256'(ahs0), 256'(1));
    @(negedge clk); @(posedge clk); #1;
    rst = 0; en = 0; aw_got = 0; w_got = 0; wr_pend = 0; rd_pend = 0;
    model_reset();
    repeat (2) begin @(posedge clk); #1; end
    check("t7_bvalid",  256'(s_axi_bvalid), 256'(0));
    check("t7_wready",  256'(s_axi_wready), 256'(0));
    check("t7_reg_out", 256'(reg_out[223:0]), 256'(0));
    rst = 1;
    #3;
    check("t7_still_off", 256'(s_axi_awready), 256'(0));
    @(posedge clk); #1; en = 1;
    check("t7_ready_back", 256'(s_axi_awready), 256'(1));
    axi_write(16'h0008, 32'h0000BEEF, 4'b0011, 0, 0, 0, br);
    axi_read(16'h0008, 0, got, rr);
    check("t7_rdata", 256'(got), 256'(32'h0000BEEF));

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
